// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl
//  Description : Sequencer for one AES block encryption. Fetches each round
//                key from the key-expansion unit, launches the round datapath
//                once per round and hands the finished block downstream.
//                Control only: no block data passes through this module.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
  parameter int NUM_ROUNDS  = 10,   // 10, 12 or 14 (AES-128/192/256)
  parameter int KEY_TIMEOUT = 255,  // key wait limit in cycles
  parameter int RND_W       = 4     // round counter / key index width
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low
  input  logic             i_abort,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_key_req,
  output logic [RND_W-1:0] o_key_idx,
  input  logic             i_key_valid,
  output logic             o_rnd_start,
  output logic             o_rnd_first,
  output logic             o_rnd_last,
  input  logic             i_rnd_done,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_busy,
  output logic             o_err
);

  // The timeout counter only has to reach KEY_TIMEOUT-1.
  localparam int TMO_W = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;

  localparam logic [TMO_W-1:0] c_tmo_last   = TMO_W'(KEY_TIMEOUT - 1);
  localparam logic [RND_W-1:0] c_round_last = RND_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_RND  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RND_W-1:0] r_round;
  logic [RND_W-1:0] w_round_nxt;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic             r_rnd_start;
  logic             w_rnd_start_nxt;
  logic             r_err;
  logic             w_err_nxt;

  // State, round counter, key timeout and the two pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_round     <= '0;
      r_tmo       <= '0;
      r_rnd_start <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_round     <= w_round_nxt;
      r_tmo       <= w_tmo_nxt;
      r_rnd_start <= w_rnd_start_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state logic; abort overrides every transition computed in the case.
  always_comb begin
    w_state_nxt     = r_state;
    w_round_nxt     = r_round;
    w_tmo_nxt       = r_tmo;
    w_rnd_start_nxt = 1'b0;
    w_err_nxt       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_in_valid) begin
          w_state_nxt = ST_KEY;
          w_round_nxt = '0;
          w_tmo_nxt   = '0;
        end
      end

      ST_KEY: begin
        if (i_key_valid) begin
          // The start pulse lands in the first RND cycle.
          w_state_nxt     = ST_RND;
          w_rnd_start_nxt = 1'b1;
        end else if (r_tmo == c_tmo_last) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
          w_round_nxt = '0;
          w_tmo_nxt   = '0;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end

      ST_RND: begin
        // A done seen alongside the start pulse belongs to no round yet.
        if (i_rnd_done && !r_rnd_start) begin
          if (r_round >= c_round_last) begin
            w_state_nxt = ST_OUT;
          end else begin
            w_state_nxt = ST_KEY;
            w_round_nxt = r_round + RND_W'(1);
            w_tmo_nxt   = '0;
          end
        end
      end

      ST_OUT: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
          w_round_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_round_nxt = '0;
        w_tmo_nxt   = '0;
      end
    endcase

    if (i_abort) begin
      w_state_nxt     = ST_IDLE;
      w_round_nxt     = '0;
      w_tmo_nxt       = '0;
      w_rnd_start_nxt = 1'b0;
      w_err_nxt       = 1'b0;
    end
  end

  // Outputs come only from registers and the state decode, so no input
  // reaches an output combinationally. The round counter is cleared on
  // every return to IDLE, which gives key_idx=0 there while it still holds
  // the last round through RND and OUT.
  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_key_req   = (r_state == ST_KEY);
  assign o_key_idx   = r_round;
  assign o_rnd_start = r_rnd_start;
  assign o_rnd_first = (r_state == ST_RND) && (r_round == '0);
  assign o_rnd_last  = (r_state == ST_RND) && (r_round == c_round_last);
  assign o_out_valid = (r_state == ST_OUT);
  assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_ctrl
//  Description : Directed bench for aes_round_ctrl. Instance 0 runs AES-128
//                with a short key timeout, instance 1 runs AES-256.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

  localparam int RND_W = 4;
  localparam int NR0   = 10;
  localparam int NR1   = 14;
  localparam logic [11:0] c_idle_outs = 12'h800;  // in_ready=1, all else 0

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [2];
  logic abort [2];
  logic in_valid [2];
  logic key_valid [2];
  logic rnd_done [2];
  logic out_ready [2];
  logic in_ready [2];
  logic key_req [2];
  logic rnd_start [2];
  logic rnd_first [2];
  logic rnd_last [2];
  logic out_valid [2];
  logic busy [2];
  logic err [2];
  logic [RND_W-1:0] key_idx [2];

  int n_tests = 0;
  int n_fail  = 0;

  aes_round_ctrl #(.NUM_ROUNDS(NR0), .KEY_TIMEOUT(8), .RND_W(RND_W)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .i_abort(abort[0]),
    .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
    .o_key_req(key_req[0]), .o_key_idx(key_idx[0]), .i_key_valid(key_valid[0]),
    .o_rnd_start(rnd_start[0]), .o_rnd_first(rnd_first[0]), .o_rnd_last(rnd_last[0]),
    .i_rnd_done(rnd_done[0]), .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]),
    .o_busy(busy[0]), .o_err(err[0])
  );

  aes_round_ctrl #(.NUM_ROUNDS(NR1), .KEY_TIMEOUT(255), .RND_W(RND_W)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .i_abort(abort[1]),
    .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
    .o_key_req(key_req[1]), .o_key_idx(key_idx[1]), .i_key_valid(key_valid[1]),
    .o_rnd_start(rnd_start[1]), .o_rnd_first(rnd_first[1]), .o_rnd_last(rnd_last[1]),
    .i_rnd_done(rnd_done[1]), .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]),
    .o_busy(busy[1]), .o_err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] outs(input int d);
    return {in_ready[d], key_req[d], key_idx[d], rnd_start[d], rnd_first[d],
            rnd_last[d], out_valid[d], busy[d], err[d]};
  endfunction

  // Results of the most recent run_block call.
  int          res_lat, res_starts, res_tag_bad, res_first, res_last;
  int          res_err, res_hold, res_ov, res_ov_idx, res_inrdy_bad;
  bit          res_done;
  logic [11:0] res_post;

  // Pushes one block through DUT d. Cycle c counts from the acceptance cycle.
  // kill_mode: 0 none, 1 abort in the rnd_start cycle of kill_rnd,
  //            2 reset low in the KEY state of kill_rnd.
  task automatic run_block(input int d, input int nr, input int dly_rnd, input int dly_n,
                           input int stall_n, input bit spur, input int kill_mode,
                           input int kill_rnd);
    int waited = 0;
    bit prev_start = 0;
    bit hs = 0;
    bit killed = 0;
    res_lat = -1; res_starts = 0; res_tag_bad = 0; res_first = 0; res_last = 0;
    res_err = 0; res_hold = 0; res_ov = 0; res_ov_idx = -1; res_inrdy_bad = 0;
    res_done = 0; res_post = '0;
    @(negedge clk);
    in_valid[d] = 1'b1; key_valid[d] = 1'b1; rnd_done[d] = 1'b0;
    out_ready[d] = (stall_n == 0); abort[d] = 1'b0;
    for (int c = 1; c <= 300 && !res_done; c++) begin
      @(negedge clk);
      if (hs || killed) begin
        res_post = outs(d);
        abort[d] = 1'b0; rst_n[d] = 1'b1; in_valid[d] = 1'b0;
        out_ready[d] = 1'b0; rnd_done[d] = 1'b0;
        res_done = 1'b1;
      end else begin
        if (rnd_start[d]) begin
          if (key_idx[d] != RND_W'(res_starts)) res_tag_bad++;
          if (rnd_first[d] != (res_starts == 0)) res_tag_bad++;
          if (rnd_last[d] != (res_starts == nr)) res_tag_bad++;
          res_starts++;
        end
        if (rnd_first[d]) res_first++;
        if (rnd_last[d]) res_last++;
        if (err[d]) res_err++;
        if (key_req[d] && key_idx[d] == RND_W'(dly_rnd)) res_hold++;
        if (out_valid[d]) begin
          if (res_ov == 0) begin
            res_lat    = c;
            res_ov_idx = int'(key_idx[d]);
          end
          res_ov++;
          if (in_ready[d]) res_inrdy_bad++;
        end
        // Stimulus for the edge that closes this cycle.
        in_valid[d]  = out_valid[d];
        key_valid[d] = 1'b1;
        if (key_req[d] && key_idx[d] == RND_W'(dly_rnd) && waited < dly_n) begin
          key_valid[d] = 1'b0;
          waited++;
        end
        rnd_done[d]  = prev_start | (spur & (rnd_start[d] | key_req[d]));
        prev_start   = rnd_start[d];
        out_ready[d] = out_valid[d] ? (res_ov > stall_n) : (stall_n == 0);
        hs = out_valid[d] && out_ready[d];
        if (kill_mode == 1 && rnd_start[d] && key_idx[d] == RND_W'(kill_rnd)) begin
          abort[d] = 1'b1;
          killed   = 1'b1;
        end
        if (kill_mode == 2 && key_req[d] && key_idx[d] == RND_W'(kill_rnd)) begin
          rst_n[d] = 1'b0;
          killed   = 1'b1;
        end
      end
    end
  endtask

  task automatic check_run(input string tag, input int nr, input int exp_lat, input int exp_ov);
    check({tag, " finished"}, res_done, 1);
    check({tag, " rnd_start count"}, res_starts, nr + 1);
    check({tag, " latency"}, res_lat, exp_lat);
    check({tag, " round tags"}, res_tag_bad, 0);
    check({tag, " rnd_first cycles"}, res_first, 2);
    check({tag, " rnd_last cycles"}, res_last, 2);
    check({tag, " err pulses"}, res_err, 0);
    check({tag, " out_valid cycles"}, res_ov, exp_ov);
    check({tag, " key_idx in OUT"}, res_ov_idx, nr);
    check({tag, " in_ready during OUT"}, res_inrdy_bad, 0);
    check({tag, " idle after handshake"}, res_post, c_idle_outs);
  endtask

  task automatic run_timeout(input int d);
    int err_at = -1;
    int errs = 0;
    int starts = 0;
    int reqs = 0;
    logic [11:0] at_err = '0;
    @(negedge clk);
    in_valid[d] = 1'b1; key_valid[d] = 1'b0; rnd_done[d] = 1'b0; out_ready[d] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      in_valid[d] = 1'b0;
      if (key_req[d]) reqs++;
      if (rnd_start[d]) starts++;
      if (err[d]) begin
        errs++;
        if (err_at < 0) begin
          err_at = c;
          at_err = outs(d);
        end
      end
    end
    key_valid[d] = 1'b1;
    // Eight KEY cycles (c=1..8), then the pulse in the first IDLE cycle.
    check("timeout key_req cycles", reqs, 8);
    check("timeout err cycle", err_at, 9);
    check("timeout err count", errs, 1);
    check("timeout outputs at err", at_err, 12'h801);
    check("timeout rnd_start count", starts, 0);
    check("timeout idle after", outs(d), c_idle_outs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; abort[d] = 1'b0; in_valid[d] = 1'b0;
      key_valid[d] = 1'b0; rnd_done[d] = 1'b0; out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("reset outs dut0", outs(0), c_idle_outs);
    check("reset outs dut1", outs(1), c_idle_outs);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    check("idle outs dut0", outs(0), c_idle_outs);

    // 1) earliest handshakes, 11 rounds, 3*11+1 cycles
    run_block(0, NR0, -1, 0, 0, 1'b0, 0, 0);
    check_run("t1", NR0, 34, 1);

    // 2) key for round 3 five cycles late
    run_block(0, NR0, 3, 5, 0, 1'b0, 0, 0);
    check_run("t2", NR0, 39, 1);
    check("t2 key_req hold round 3", res_hold, 6);

    // 3) key never arrives
    run_timeout(0);

    // 4) downstream stalls four cycles, in_valid offered during OUT
    run_block(0, NR0, -1, 0, 4, 1'b0, 0, 0);
    check_run("t4", NR0, 34, 5);

    // 5a) abort in RND of round 6, then a clean block
    run_block(0, NR0, -1, 0, 0, 1'b0, 1, 6);
    check("t5a killed", res_done, 1);
    check("t5a starts before abort", res_starts, 7);
    check("t5a outs after abort", res_post, c_idle_outs);
    check("t5a no out_valid", res_ov, 0);
    check("t5a no err", res_err, 0);
    run_block(0, NR0, -1, 0, 0, 1'b0, 0, 0);
    check_run("t5a rerun", NR0, 34, 1);

    // 5b) reset low in KEY of round 2, then a clean block
    run_block(0, NR0, -1, 0, 0, 1'b0, 2, 2);
    check("t5b killed", res_done, 1);
    check("t5b starts before reset", res_starts, 2);
    check("t5b outs after reset", res_post, c_idle_outs);
    run_block(0, NR0, -1, 0, 0, 1'b0, 0, 0);
    check_run("t5b rerun", NR0, 34, 1);

    // 6) AES-256 with spurious rnd_done in KEY and alongside rnd_start
    run_block(1, NR1, -1, 0, 0, 1'b1, 0, 0);
    check_run("t6", NR1, 46, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
